booth_shreg: RTL

- Parametrised successor of the team's fixed 6-bit serial/parallel shift register, used for the multiplier/accumulator operands of the Booth datapath.
- Adds configurable width, radix step (1 bit for radix-2, 2 bits for radix-4 Booth), left/right direction and arithmetic (sign-fill) right shift.
- Adds an autonomous N-step shift sequencer with busy/done handshake, so the controller FSM can issue one "shift N" command instead of N single-step pulses.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_shreg_seq.sv | 80 ++++++++
 rtl/booth_shreg.sv | 123 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth datapath operand shift register.
// Holds the direction encoding, the sequencer state type and the legal STEP values.
package booth_pkg;

    // Shift direction encoding (dir input and latched copy)
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Legal bits-per-shift values: radix-2 and radix-4 Booth
    localparam int STEP_R2 = 1;
    localparam int STEP_R4 = 2;

    // Auto-shift sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/booth_shreg_seq.sv
// N-step shift sequencer for booth_shreg.
// Accepts a "shift N" command while idle, then produces one shift enable per
// cycle for exactly N cycles, with busy while running and a one-cycle done
// pulse coinciding with busy falling. A zero count produces only done.
module booth_shreg_seq
    import booth_pkg::*;
#(
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            init_i,
    input  logic            ld_i,
    input  logic            start_i,
    input  logic [CNTW-1:0] cnt_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            shift_en_o,
    output logic            accept_o
);

    seq_state_e      state_q, state_d;
    logic [CNTW-1:0] left_q,  left_d;
    logic            done_q,  done_d;

    // Next-state logic: init aborts silently; ld outranks start while idle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        left_d     = left_q;
        done_d     = 1'b0;
        shift_en_o = 1'b0;
        accept_o   = 1'b0;
        if (init_i) begin
            state_d = IDLE;
            left_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && !ld_i) begin
                        if (cnt_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d  = RUN;
                            left_d   = cnt_i;
                            accept_o = 1'b1;
                        end
                    end
                end
                RUN: begin
                    shift_en_o = 1'b1;
                    left_d     = left_q - CNTW'(1);
                    if (left_q == CNTW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, remaining-step counter and done pulse registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
            left_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;

endmodule

// File: rtl/booth_shreg.sv
// Parametrised serial/parallel shift register for Booth multiplier operands.
// Supports WIDTH bits, STEP (1 or 2) bits per shift, left/right direction,
// arithmetic right shift and an autonomous N-step shift sequence.
// Optional: define SHREG_ROTATE_EN to add the rot input (rotate instead of fill).
module booth_shreg
    import booth_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int STEP  = STEP_R2,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             ld,
    input  logic             sh,
    input  logic             dir,
    input  logic             arith,
`ifdef SHREG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             start,
    input  logic [CNTW-1:0]  cnt,
    input  logic [STEP-1:0]  serin,
    input  logic [WIDTH-1:0] parin,
    output logic [WIDTH-1:0] parout,
    output logic [STEP-1:0]  serout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] par_q, par_d;
    logic [WIDTH-1:0] shifted;
    logic [STEP-1:0]  fill;
    logic             dir_q, arith_q, rot_q;
    logic             rot_live;
    logic             eff_dir, eff_arith, eff_rot;
    logic             shift_en, accept;

`ifdef SHREG_ROTATE_EN
    assign rot_live = rot;
`else
    assign rot_live = 1'b0;
`endif

    booth_shreg_seq #(
        .CNTW (CNTW)
    ) u_seq (
        .clk        (clk),
        .rst_ni     (rst),
        .init_i     (init),
        .ld_i       (ld),
        .start_i    (start),
        .cnt_i      (cnt),
        .busy_o     (busy),
        .done_o     (done),
        .shift_en_o (shift_en),
        .accept_o   (accept)
    );

    // While a sequence runs the mode bits come from the copy latched at start.
    assign eff_dir   = busy ? dir_q   : dir;
    assign eff_arith = busy ? arith_q : arith;
    assign eff_rot   = busy ? rot_q   : rot_live;

    // One shift step in the effective direction with the selected fill source.
    always_comb begin
        fill    = serin;
        shifted = par_q;
        if (eff_dir == DIR_RIGHT) begin
            if (eff_rot) begin
                fill = par_q[STEP-1:0];
            end else if (eff_arith) begin
                fill = {STEP{par_q[WIDTH-1]}};
            end
            shifted = {fill, par_q[WIDTH-1:STEP]};
        end else begin
            if (eff_rot) begin
                fill = par_q[WIDTH-1:WIDTH-STEP];
            end
            shifted = {par_q[WIDTH-1-STEP:0], fill};
        end
    end

    // Register next value: init > ld > start > sh; only the sequencer shifts while busy.
    always_comb begin
        par_d = par_q;
        if (init) begin
            par_d = '0;
        end else if (busy) begin
            if (shift_en) begin
                par_d = shifted;
            end
        end else if (ld) begin
            par_d = parin;
        end else if (start) begin
            par_d = par_q;
        end else if (sh) begin
            par_d = shifted;
        end
    end

    // Datapath register and the mode bits captured when a sequence is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q   <= '0;
            dir_q   <= DIR_RIGHT;
            arith_q <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            par_q <= par_d;
            if (accept) begin
                dir_q   <= dir;
                arith_q <= arith;
                rot_q   <= rot_live;
            end
        end
    end

    assign parout = par_q;
    assign serout = (eff_dir == DIR_LEFT) ? par_q[WIDTH-1:WIDTH-STEP] : par_q[STEP-1:0];

endmodule
